led_serial_receiver: RTL and testbench

- Receive-side counterpart of LED_Driver: deserializes the LED serial link (data + latch) back into a parallel word.
- Used as a loopback checker in benches and as a bit-exact model of the external LED shift-register/latch chain.
- Sits on the LED_Driver output pins, in the same clock domain. Reports good frames, framing errors and a running frame count.

---
 rtl/led_pkg.sv | 25 ++
 rtl/led_frame_counter.sv | 37 +++
 rtl/led_serial_receiver.sv | 108 ++++++++++
 tb/tb_led_serial_receiver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED serial link: frame width, counter width and
// the per-edge link state used by both the driver and the receiver.
package led_pkg;

   localparam int unsigned LED_WIDTH = 16;
   localparam int unsigned LED_CNT_W = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StEnd   = 2'd2
   } led_state_e;

   // Link state for one clock edge, from the live latch and its previous sample.
   function automatic led_state_e led_classify(input logic latch, input logic latch_q);
      if (!latch) begin
         return StShift;
      end else if (!latch_q) begin
         return StEnd;
      end else begin
         return StIdle;
      end
   endfunction

endpackage

// File: rtl/led_frame_counter.sv
// Saturating bit counter for an LED frame; clear wins over increment.
module led_frame_counter #(
   parameter int unsigned MAX   = 17,
   parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/led_serial_receiver.sv
// Deserializes the LED data/latch link into parallel words, flagging frames
// whose bit count differs from WIDTH and counting good frames.
module led_serial_receiver
   import led_pkg::*;
#(
   parameter int unsigned WIDTH = LED_WIDTH,
   parameter int unsigned CNT_W = LED_CNT_W
) (
   input  logic             i_CLK,
   input  logic             i_RESET,
   input  logic             i_LEDData,
   input  logic             i_LEDLatch,
   output logic [WIDTH-1:0] o_Data,
   output logic             o_Valid,
   output logic             o_FrameErr,
   output logic             o_Busy,
   output logic [CNT_W-1:0] o_FrameCount
);

   // One extra count value marks an overlong frame.
   localparam int unsigned BIT_CNT_W = $clog2(WIDTH + 2);
   localparam logic [BIT_CNT_W-1:0] CNT_FULL = BIT_CNT_W'(WIDTH);

   led_state_e state;

   logic                 latch_q;
   logic [WIDTH-1:0]     sr_q, sr_d;
   logic [WIDTH-1:0]     data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic [CNT_W-1:0]     frames_q, frames_d;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic                 cnt_clr;
   logic                 cnt_inc;

   led_frame_counter #(
      .MAX   (WIDTH + 1),
      .CNT_W (BIT_CNT_W)
   ) u_bit_cnt (
      .clk   (i_CLK),
      .rst_n (i_RESET),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (bit_cnt)
   );

   always_comb begin
      state    = led_classify(i_LEDLatch, latch_q);
      sr_d     = sr_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      busy_d   = busy_q;
      frames_d = frames_q;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      unique case (state)
         StShift: begin
            sr_d    = {sr_q[WIDTH-2:0], i_LEDData};
            cnt_inc = 1'b1;
            busy_d  = 1'b1;
         end
         StEnd: begin
            if (bit_cnt == CNT_FULL) begin
               data_d   = sr_q;
               valid_d  = 1'b1;
               frames_d = frames_q + CNT_W'(1);
            end else begin
               err_d = 1'b1;
            end
            cnt_clr = 1'b1;
            busy_d  = 1'b0;
         end
         StIdle: begin
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RESET) begin
      if (!i_RESET) begin
         latch_q  <= 1'b1;
         sr_q     <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         frames_q <= '0;
      end else begin
         latch_q  <= i_LEDLatch;
         sr_q     <= sr_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         frames_q <= frames_d;
      end
   end

   assign o_Data       = data_q;
   assign o_Valid      = valid_q;
   assign o_FrameErr   = err_q;
   assign o_Busy       = busy_q;
   assign o_FrameCount = frames_q;

endmodule

// File: tb/tb_led_serial_receiver.sv
// Bench for led_serial_receiver: frame-level queue model checked every cycle,
// plus literal expectations at the scenario boundaries.
module tb_led_serial_receiver;

   localparam int WIDTH = 16;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             latch = 1'b1;
   logic             sdata = 1'b0;
   logic [WIDTH-1:0] dut_data;
   logic             dut_valid;
   logic             dut_err;
   logic             dut_busy;
   logic [CNT_W-1:0] dut_count;

   int total = 0;
   int bad = 0;
   int valid_seen = 0;
   int err_seen = 0;

   led_serial_receiver #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .i_CLK        (clk),
      .i_RESET      (rst_n),
      .i_LEDData    (sdata),
      .i_LEDLatch   (latch),
      .o_Data       (dut_data),
      .o_Valid      (dut_valid),
      .o_FrameErr   (dut_err),
      .o_Busy       (dut_busy),
      .o_FrameCount (dut_count)
   );

   always #5 clk = ~clk;

   // Frame-level model: collect bits while latch is low, judge the frame when latch rises.
   logic             m_bits[$];
   logic [WIDTH-1:0] m_data = '0;
   logic             m_valid = 1'b0;
   logic             m_err = 1'b0;
   logic             m_busy = 1'b0;
   int               m_count = 0;
   logic             m_prev_latch = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_bits.delete();
         m_data = '0;
         m_valid = 1'b0;
         m_err = 1'b0;
         m_busy = 1'b0;
         m_count = 0;
         m_prev_latch = 1'b1;
      end else begin
         m_valid = 1'b0;
         m_err = 1'b0;
         if (!latch) begin
            m_bits.push_back(sdata);
            m_busy = 1'b1;
         end else if (!m_prev_latch) begin
            if (m_bits.size() == WIDTH) begin
               for (int i = 0; i < WIDTH; i++) m_data[WIDTH-1-i] = m_bits[i];
               m_count = (m_count + 1) % (1 << CNT_W);
               m_valid = 1'b1;
            end else begin
               m_err = 1'b1;
            end
            m_bits.delete();
            m_busy = 1'b0;
         end
         m_prev_latch = latch;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      #2;
      check("data", 32'(dut_data), 32'(m_data));
      check("valid", 32'(dut_valid), 32'(m_valid));
      check("frame_err", 32'(dut_err), 32'(m_err));
      check("busy", 32'(dut_busy), 32'(m_busy));
      check("frame_count", 32'(dut_count), 32'(m_count));
      if (dut_valid && dut_err) check("pulse_overlap", 32'd1, 32'd0);
      if (dut_valid) valid_seen++;
      if (dut_err) err_seen++;
   end

   task automatic drive(input logic l, input logic d);
      @(negedge clk);
      latch = l;
      sdata = d;
   endtask

   // n bits of v, MSB first, then a single latch-high cycle.
   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) drive(1'b0, v[i]);
      drive(1'b1, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1, 1'b0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      latch = 1'b1;
      sdata = 1'b0;
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Lands in the cycle right after the latch-rise edge.
   task automatic after_edge();
      @(negedge clk);
      #3;
   endtask

   int v0;
   int e0;

   initial begin
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      idle(20);
      #3;
      check("reset_data", 32'(dut_data), 32'h0);
      check("reset_count", 32'(dut_count), 32'h0);
      check("reset_busy", 32'(dut_busy), 32'h0);
      check("reset_no_pulses", 32'(valid_seen + err_seen), 32'h0);

      // Single frame
      send_bits(32'h9D1F, 16);
      after_edge();
      check("single_valid", 32'(dut_valid), 32'h1);
      check("single_data", 32'(dut_data), 32'h9D1F);
      check("single_count", 32'(dut_count), 32'h1);
      after_edge();
      check("single_valid_one_cycle", 32'(dut_valid), 32'h0);

      // Short, long and glitch frames
      e0 = err_seen;
      send_bits(32'h1234, 15);
      after_edge();
      check("short_err", 32'(dut_err), 32'h1);
      send_bits(32'h1ABCD, 17);
      after_edge();
      check("long_err", 32'(dut_err), 32'h1);
      send_bits(32'h1, 1);
      after_edge();
      check("glitch_err", 32'(dut_err), 32'h1);
      check("err_data_kept", 32'(dut_data), 32'h9D1F);
      check("err_count_kept", 32'(dut_count), 32'h1);
      check("err_pulses", 32'(err_seen - e0), 32'h3);

      // Back-to-back frames with one latch-high cycle between
      do_reset(3);
      v0 = valid_seen;
      send_bits(32'h9D1F, 16);
      send_bits(32'h0001, 16);
      send_bits(32'hFFFF, 16);
      idle(3);
      #3;
      check("b2b_pulses", 32'(valid_seen - v0), 32'h3);
      check("b2b_data", 32'(dut_data), 32'hFFFF);
      check("b2b_count", 32'(dut_count), 32'h3);

      // Reset in the middle of a frame
      for (int i = 0; i < 8; i++) drive(1'b0, 1'(i));
      do_reset(3);
      #3;
      check("midrst_data", 32'(dut_data), 32'h0);
      check("midrst_count", 32'(dut_count), 32'h0);
      check("midrst_busy", 32'(dut_busy), 32'h0);
      send_bits(32'h1234, 16);
      after_edge();
      check("post_rst_data", 32'(dut_data), 32'h1234);
      check("post_rst_count", 32'(dut_count), 32'h1);

      // Frame-count wrap
      do_reset(2);
      for (int i = 1; i <= 256; i++) begin
         send_bits(32'(i * 7), 16);
         after_edge();
         if (i == 255) check("wrap_count_255", 32'(dut_count), 32'hFF);
         if (i == 256) begin
            check("wrap_count_0", 32'(dut_count), 32'h0);
            check("wrap_valid", 32'(dut_valid), 32'h1);
            check("wrap_data", 32'(dut_data), 32'd1792);
         end
      end
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
